// File: rtl/core_pkg.sv
// Shared core definitions: load funct3 encodings and writeback-stage FSM states.
package core_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic [0:0] {
        WB_IDLE,
        WB_WAIT_LOAD
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational byte/half/word selection and extension of a raw
// 32-bit dmem word by byte offset and funct3, plus misalignment detection.
// Unlisted funct3 codes (3/6/7) behave as LW.
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data,
    output logic            o_misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed byte/half and extend according to the load type
    always_comb begin
        byte_v     = 8'(i_rdata >> {i_off, 3'b000});
        half_v     = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_data     = i_rdata;
        o_misalign = 1'b0;
        case (i_funct3)
            LD_LB: begin
                o_data = {{(XLEN-8){byte_v[7]}}, byte_v};
            end
            LD_LBU: begin
                o_data = {{(XLEN-8){1'b0}}, byte_v};
            end
            LD_LH: begin
                o_data     = {{(XLEN-16){half_v[15]}}, half_v};
                o_misalign = i_off[0];
            end
            LD_LHU: begin
                o_data     = {{(XLEN-16){1'b0}}, half_v};
                o_misalign = i_off[0];
            end
            default: begin
                o_data     = i_rdata;
                o_misalign = (i_off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: execute->writeback pipeline stage. Retires ALU results the cycle
// after accept; loads wait in WB_WAIT_LOAD (stalling the front end) until the
// dmem response arrives, then write back aligned/extended data.
// Optional feature macro: WB_PERF_CNT_EN adds o_load_stall_cnt, a saturating
// count of cycles spent waiting for load data.
module wb_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ex_valid,
    output logic            o_ex_ready,
    input  logic            i_ex_reg_write,
    input  logic [RD_W-1:0] i_ex_rd,
    input  logic [XLEN-1:0] i_ex_alu_result,
    input  logic            i_ex_mem_read,
    input  logic [2:0]      i_ex_funct3,
    input  logic            i_dmem_rsp_valid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_wb_reg_write,
    output logic [RD_W-1:0] o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_misalign,
    output logic            o_stall
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]     o_load_stall_cnt
`endif
);

    wb_state_e       state_q, state_d;
    logic            wb_reg_write_q, wb_reg_write_d;
    logic [RD_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            misalign_q, misalign_d;
    logic [RD_W-1:0] pend_rd_q, pend_rd_d;
    logic            pend_we_q, pend_we_d;
    logic [2:0]      pend_f3_q, pend_f3_d;
    logic [1:0]      pend_off_q, pend_off_d;

    logic [XLEN-1:0] al_data;
    logic            al_misalign;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_rdata    (i_dmem_rdata),
        .i_off      (pend_off_q),
        .i_funct3   (pend_f3_q),
        .o_data     (al_data),
        .o_misalign (al_misalign)
    );

    // Next-state logic: accept in IDLE, retire loads on the dmem response
    always_comb begin
        state_d        = state_q;
        wb_reg_write_d = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        misalign_d     = 1'b0;
        pend_rd_d      = pend_rd_q;
        pend_we_d      = pend_we_q;
        pend_f3_d      = pend_f3_q;
        pend_off_d     = pend_off_q;
        case (state_q)
            WB_IDLE: begin
                // A response arriving here is spurious and deliberately ignored
                if (i_ex_valid) begin
                    if (i_ex_mem_read) begin
                        pend_rd_d  = i_ex_rd;
                        pend_we_d  = i_ex_reg_write;
                        pend_f3_d  = i_ex_funct3;
                        pend_off_d = i_ex_alu_result[1:0];
                        state_d    = WB_WAIT_LOAD;
                    end else begin
                        wb_data_d      = i_ex_alu_result;
                        wb_rd_d        = i_ex_rd;
                        wb_reg_write_d = i_ex_reg_write & (i_ex_rd != '0);
                    end
                end
            end
            WB_WAIT_LOAD: begin
                if (i_dmem_rsp_valid) begin
                    state_d = WB_IDLE;
                    if (al_misalign) begin
                        // Misaligned load is dropped: no RF write, rd/data hold
                        misalign_d = 1'b1;
                    end else begin
                        wb_data_d      = al_data;
                        wb_rd_d        = pend_rd_q;
                        wb_reg_write_d = pend_we_q & (pend_rd_q != '0);
                    end
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // State and output registers; async reset abandons any outstanding load
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= WB_IDLE;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            misalign_q     <= 1'b0;
            pend_rd_q      <= '0;
            pend_we_q      <= 1'b0;
            pend_f3_q      <= '0;
            pend_off_q     <= '0;
        end else begin
            state_q        <= state_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            misalign_q     <= misalign_d;
            pend_rd_q      <= pend_rd_d;
            pend_we_q      <= pend_we_d;
            pend_f3_q      <= pend_f3_d;
            pend_off_q     <= pend_off_d;
        end
    end

    assign o_ex_ready     = (state_q == WB_IDLE);
    assign o_stall        = (state_q == WB_WAIT_LOAD);
    assign o_wb_reg_write = wb_reg_write_q;
    assign o_wb_rd        = wb_rd_q;
    assign o_wb_data      = wb_data_q;
    assign o_misalign     = misalign_q;

`ifdef WB_PERF_CNT_EN
    logic [31:0] load_stall_cnt_q, load_stall_cnt_d;

    // Saturating count of cycles spent waiting for load data
    always_comb begin
        load_stall_cnt_d = load_stall_cnt_q;
        if ((state_q == WB_WAIT_LOAD) && (load_stall_cnt_q != '1)) begin
            load_stall_cnt_d = load_stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            load_stall_cnt_q <= '0;
        end else begin
            load_stall_cnt_q <= load_stall_cnt_d;
        end
    end

    assign o_load_stall_cnt = load_stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with an expected-writeback scoreboard.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// Define WB_PERF_CNT_EN to also exercise the load stall counter.
module tb_wb_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_reg_write, ex_mem_read, rsp_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu, rdata;
    logic [2:0]  ex_f3;
    logic        ex_ready, wb_we, misalign, stall;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef WB_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        cmp_data;
    } exp_t;

    exp_t sb[$];

    wb_stage #(
        .XLEN (32),
        .RD_W (5)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_ex_valid       (ex_valid),
        .o_ex_ready       (ex_ready),
        .i_ex_reg_write   (ex_reg_write),
        .i_ex_rd          (ex_rd),
        .i_ex_alu_result  (ex_alu),
        .i_ex_mem_read    (ex_mem_read),
        .i_ex_funct3      (ex_f3),
        .i_dmem_rsp_valid (rsp_valid),
        .i_dmem_rdata     (rdata),
        .o_wb_reg_write   (wb_we),
        .o_wb_rd          (wb_rd),
        .o_wb_data        (wb_data),
        .o_misalign       (misalign),
        .o_stall          (stall)
`ifdef WB_PERF_CNT_EN
        ,
        .o_load_stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected writeback and compare it with the DUT outputs
    task automatic retire_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_we"}, wb_we, e.we);
            chk({tag, "_mis"}, misalign, e.mis);
            if (e.cmp_data) begin
                chk({tag, "_rd"}, wb_rd, e.rd);
                chk({tag, "_data"}, wb_data, e.data);
            end
        end
    endtask

    task automatic alu_op(input logic we, input logic [4:0] rd, input logic [31:0] res,
                          input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, ex_ready, 1'b1);
        ex_valid = 1'b1; ex_mem_read = 1'b0; ex_reg_write = we; ex_rd = rd;
        ex_alu = res; ex_f3 = 3'b000;
        sb.push_back('{we: we & (rd != 5'd0), rd: rd, data: res, mis: 1'b0, cmp_data: 1'b1});
        @(negedge clk);
        ex_valid = 1'b0;
        retire_check(tag);
        @(negedge clk);
        chk({tag, "_we_1cyc"}, wb_we, 1'b0);
        chk({tag, "_data_hold"}, wb_data, res);
    endtask

    task automatic load_op(input logic we, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] word, input int waits,
                           input logic [31:0] exp_data, input logic exp_mis, input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, ex_ready, 1'b1);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_write = we; ex_rd = rd;
        ex_alu = addr; ex_f3 = f3;
        sb.push_back('{we: we & (rd != 5'd0) & ~exp_mis, rd: rd, data: exp_data,
                       mis: exp_mis, cmp_data: ~exp_mis});
        @(negedge clk);
        ex_valid = 1'b0;
        for (int k = 0; k < waits; k++) begin
            chk({tag, "_stall"}, stall, 1'b1);
            chk({tag, "_wait_we"}, wb_we, 1'b0);
            if (k == waits - 1) begin
                rsp_valid = 1'b1;
                rdata = word;
            end
            @(negedge clk);
        end
        rsp_valid = 1'b0;
        rdata = 32'hDEAD_BEEF;
        retire_check(tag);
        chk({tag, "_stall_off"}, stall, 1'b0);
        chk({tag, "_ready_back"}, ex_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; rsp_valid = 1'b0;
        ex_rd = '0; ex_alu = '0; ex_f3 = '0; rdata = '0;

        // Reset state
        #12;
        chk("rst_we", wb_we, 1'b0);
        chk("rst_rd", wb_rd, 5'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_mis", misalign, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_ready", ex_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU retire
        alu_op(1'b1, 5'd5, 32'h0000_1234, "alu_rd5");
        alu_op(1'b0, 5'd9, 32'hCAFE_0001, "alu_nowe");

        // Loads: sign/zero extension and alignment
        load_op(1'b1, 5'd3, 32'h0000_1003, LD_LB,  32'h8000_0000, 3, 32'hFFFF_FF80, 1'b0, "lb_off3");
        load_op(1'b1, 5'd4, 32'h0000_1003, LD_LBU, 32'h8000_0000, 3, 32'h0000_0080, 1'b0, "lbu_off3");
        load_op(1'b1, 5'd6, 32'h0000_2002, LD_LH,  32'hBEEF_0000, 1, 32'hFFFF_BEEF, 1'b0, "lh_off2");
        load_op(1'b1, 5'd7, 32'h0000_2000, LD_LHU, 32'h1234_8001, 2, 32'h0000_8001, 1'b0, "lhu_off0");
        load_op(1'b1, 5'd8, 32'h0000_3001, LD_LB,  32'h0000_7F00, 1, 32'h0000_007F, 1'b0, "lb_off1");
        load_op(1'b1, 5'd10, 32'h0000_4000, LD_LW, 32'h89AB_CDEF, 2, 32'h89AB_CDEF, 1'b0, "lw_off0");
        load_op(1'b1, 5'd11, 32'h0000_4000, 3'b111, 32'h0F0F_0F0F, 1, 32'h0F0F_0F0F, 1'b0, "f3_7_as_lw");

        // Misaligned loads
        load_op(1'b1, 5'd12, 32'h0000_4001, LD_LW, 32'h1111_1111, 1, 32'h0, 1'b1, "lw_mis");
        @(negedge clk);
        chk("lw_mis_pulse_end", misalign, 1'b0);
        chk("lw_mis_data_hold", wb_data, 32'h0F0F_0F0F);
        load_op(1'b1, 5'd13, 32'h0000_4003, LD_LHU, 32'h2222_2222, 2, 32'h0, 1'b1, "lhu_mis");

        // rd = 0 never writes
        alu_op(1'b1, 5'd0, 32'h0000_5555, "alu_rd0");
        load_op(1'b1, 5'd0, 32'h0000_0000, LD_LW, 32'h0000_0055, 2, 32'h0000_0055, 1'b0, "lw_rd0");

        // Spurious response in IDLE
        @(negedge clk);
        rsp_valid = 1'b1; rdata = 32'h7777_7777;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("spur_we", wb_we, 1'b0);
        chk("spur_data", wb_data, 32'h0000_0055);
        chk("spur_stall", stall, 1'b0);

        // Reset while a load is outstanding
        alu_op(1'b1, 5'd7, 32'h0000_AAAA, "pre_rst");
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9;
        ex_alu = 32'h0; ex_f3 = LD_LW;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("midrst_stall_pre", stall, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_we", wb_we, 1'b0);
        chk("midrst_rd", wb_rd, 5'd0);
        chk("midrst_data", wb_data, 32'd0);
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_mis", misalign, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b1; rdata = 32'h9999_9999;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("postrst_rsp_we", wb_we, 1'b0);
        chk("postrst_rsp_data", wb_data, 32'd0);
        alu_op(1'b1, 5'd14, 32'h0BAD_F00D, "postrst_alu");

`ifdef WB_PERF_CNT_EN
        // Stall counter: accumulation and saturation
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("cnt_rst", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_op(1'b1, 5'd1, 32'h0, LD_LW, 32'h1, 4, 32'h1, 1'b0, "cnt_ld4");
        load_op(1'b1, 5'd2, 32'h0, LD_LW, 32'h2, 2, 32'h2, 1'b0, "cnt_ld2");
        chk("cnt_six", stall_cnt, 32'd6);
        @(negedge clk);
        force dut.load_stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.load_stall_cnt_q;
        load_op(1'b1, 5'd3, 32'h0, LD_LW, 32'h3, 4, 32'h3, 1'b0, "cnt_sat_ld");
        chk("cnt_sat", stall_cnt, 32'hFFFF_FFFF);
`endif

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
